// File: rtl/sysmem_frame_loader_if.sv
// Host-side beat stream and system-memory write port of the frame-store loader.
// The loader takes the slave modport; the host/bench side takes master.
interface sysmem_frame_loader_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 8
);
    logic [DW-1:0] host_data;
    logic          host_valid;
    logic          host_last;
    logic          host_ready;
    logic [AW-1:0] sm_addr;
    logic [DW-1:0] sm_data;
    logic          sm_we;
    logic          cs_display;
    logic          disp_frame_done;
    logic          short_frame;
    logic [7:0]    frame_count;

    modport slave (
        input  host_data, host_valid, host_last, disp_frame_done,
        output host_ready, sm_addr, sm_data, sm_we, cs_display, short_frame, frame_count
    );

    modport master (
        output host_data, host_valid, host_last, disp_frame_done,
        input  host_ready, sm_addr, sm_data, sm_we, cs_display, short_frame, frame_count
    );
endinterface

// File: rtl/sysmem_frame_loader.sv
// Writes host component beats sequentially into the system-memory frame store,
// pads short frames, and hands each full frame to the display controller.
module sysmem_frame_loader #(
    parameter int unsigned   DEPTH = 100,
    parameter int unsigned   AW    = 7,
    parameter int unsigned   DW    = 8,
    parameter logic [DW-1:0] PAD   = '0
) (
    input logic                  clock_i,
    input logic                  reset_ni,
    sysmem_frame_loader_if.slave bus
);
    typedef enum logic [1:0] {StLoad, StPad, StHandoff, StWaitDone} state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          host_ready_q;
    logic [AW-1:0] sm_addr_q;
    logic [DW-1:0] sm_data_q;
    logic          sm_we_q;
    logic          cs_display_q;
    logic          short_frame_q;
    logic [7:0]    frame_count_q;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q       <= StLoad;
            cnt_q         <= '0;
            host_ready_q  <= 1'b0;
            sm_addr_q     <= '0;
            sm_data_q     <= '0;
            sm_we_q       <= 1'b0;
            cs_display_q  <= 1'b0;
            short_frame_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            sm_we_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    host_ready_q <= 1'b1;
                    if (bus.host_valid && host_ready_q) begin
                        sm_we_q   <= 1'b1;
                        sm_addr_q <= cnt_q;
                        sm_data_q <= bus.host_data;
                        if (cnt_q == '0) begin
                            short_frame_q <= 1'b0;
                        end
                        // HostLast on the final address is the normal end of frame.
                        if (cnt_q == LastAddr) begin
                            state_q      <= StHandoff;
                            host_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (bus.host_last) begin
                                short_frame_q <= 1'b1;
                                state_q       <= StPad;
                                host_ready_q  <= 1'b0;
                            end
                        end
                    end
                end
                StPad: begin
                    sm_we_q   <= 1'b1;
                    sm_addr_q <= cnt_q;
                    sm_data_q <= PAD;
                    if (cnt_q == LastAddr) begin
                        state_q <= StHandoff;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHandoff: begin
                    cs_display_q  <= 1'b1;
                    cnt_q         <= '0;
                    frame_count_q <= frame_count_q + 8'd1;
                    state_q       <= StWaitDone;
                end
                StWaitDone: begin
                    if (bus.disp_frame_done) begin
                        cs_display_q <= 1'b0;
                        host_ready_q <= 1'b1;
                        state_q      <= StLoad;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.host_ready  = host_ready_q;
    assign bus.sm_addr     = sm_addr_q;
    assign bus.sm_data     = sm_data_q;
    assign bus.sm_we       = sm_we_q;
    assign bus.cs_display  = cs_display_q;
    assign bus.short_frame = short_frame_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_sysmem_frame_loader.sv
// Directed bench for the frame loader: frame table plus hand-written sequences
// for hand-off timing, WAIT_DONE blocking, mid-frame reset and counter wrap.
module tb_sysmem_frame_loader;
    localparam int Depth = 100;
    localparam int PadVal = 0;

    typedef struct {
        int n;
        bit last;
        bit gaps;
        int base;
        bit exp_short_first;
        bit exp_short;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   we_cs_viol = 0;
    int   fc_model = 0;
    int   wa[$];
    int   wd[$];
    int   short_first;

    always #5 clk = ~clk;

    sysmem_frame_loader_if #(.AW(7), .DW(8)) bus ();

    sysmem_frame_loader #(
        .DEPTH(Depth),
        .AW   (7),
        .DW   (8),
        .PAD  (8'(PadVal))
    ) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.sm_we === 1'b1) begin
            wa.push_back(int'(bus.sm_addr));
            wd.push_back(int'(bus.sm_data));
        end
        if (bus.sm_we === 1'b1 && bus.cs_display === 1'b1) we_cs_viol++;
    endtask

    // Drives n beats, holding data across stalls; optional spurious frame-done pulse.
    task automatic send_frame(input int n, input bit last, input bit gaps, input int base,
                              input bit spur);
        int i = 0;
        int budget = 0;
        bit acc;
        wa.delete();
        wd.delete();
        while (i < n && budget < 2000) begin
            bus.host_valid      = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.host_data       = 8'(base + i);
            bus.host_last       = last && (i == n - 1);
            bus.disp_frame_done = spur && (i == 50);
            acc = bus.host_valid && bus.host_ready;
            tick();
            if (acc) begin
                if (i == 0) short_first = int'(bus.short_frame);
                i++;
            end
            budget++;
        end
        bus.host_valid      = 1'b0;
        bus.host_last       = 1'b0;
        bus.disp_frame_done = 1'b0;
        chk("beats_accepted", i, n);
    endtask

    task automatic wait_handoff();
        for (int t = 0; t < 300 && bus.cs_display !== 1'b1; t++) tick();
        chk("handoff_seen", int'(bus.cs_display), 1);
    endtask

    function automatic int frame_mismatches(input int n, input int base);
        int m = 0;
        if (wa.size() != Depth) return Depth;
        for (int k = 0; k < Depth; k++) begin
            if (wa[k] != k) m++;
            if (wd[k] != ((k < n) ? ((base + k) & 255) : PadVal)) m++;
        end
        return m;
    endfunction

    task automatic release_frame(input string name);
        bus.disp_frame_done = 1'b1;
        tick();
        bus.disp_frame_done = 1'b0;
        chk({name, "_cs_low"}, int'(bus.cs_display), 0);
        chk({name, "_ready"}, int'(bus.host_ready), 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, int'(bus.host_ready), 0);
        chk({name, "_we"}, int'(bus.sm_we), 0);
        chk({name, "_addr"}, int'(bus.sm_addr), 0);
        chk({name, "_data"}, int'(bus.sm_data), 0);
        chk({name, "_cs"}, int'(bus.cs_display), 0);
        chk({name, "_short"}, int'(bus.short_frame), 0);
        chk({name, "_fc"}, int'(bus.frame_count), 0);
    endtask

    initial begin
        vec_t tbl[5];
        int   bad;
        tbl[0] = '{n: 40,  last: 1'b1, gaps: 1'b0, base: 0,   exp_short_first: 1'b0, exp_short: 1'b1};
        tbl[1] = '{n: 1,   last: 1'b1, gaps: 1'b0, base: 200, exp_short_first: 1'b1, exp_short: 1'b1};
        tbl[2] = '{n: 100, last: 1'b0, gaps: 1'b1, base: 7,   exp_short_first: 1'b0, exp_short: 1'b0};
        tbl[3] = '{n: 99,  last: 1'b1, gaps: 1'b0, base: 50,  exp_short_first: 1'b0, exp_short: 1'b1};
        tbl[4] = '{n: 100, last: 1'b1, gaps: 1'b0, base: 3,   exp_short_first: 1'b0, exp_short: 1'b0};

        rst_n               = 1'b0;
        bus.host_valid      = 1'b0;
        bus.host_last       = 1'b0;
        bus.host_data       = '0;
        bus.disp_frame_done = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", int'(bus.host_ready), 1);

        // Full frame, data = index, exact hand-off timing.
        send_frame(100, 1'b0, 1'b0, 0, 1'b0);
        chk("last_write_we", int'(bus.sm_we), 1);
        chk("last_write_addr", int'(bus.sm_addr), 99);
        chk("last_write_cs", int'(bus.cs_display), 0);
        tick();
        fc_model++;
        chk("handoff_cs", int'(bus.cs_display), 1);
        chk("handoff_fc", int'(bus.frame_count), fc_model);
        chk("handoff_ready", int'(bus.host_ready), 0);
        chk("handoff_we", int'(bus.sm_we), 0);
        chk("frame0_writes", frame_mismatches(100, 0), 0);

        // Host pushes while the display owns the store.
        wa.delete();
        bad = 0;
        bus.host_valid = 1'b1;
        bus.host_data  = 8'hAA;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.host_ready !== 1'b0) bad++;
        end
        chk("hold_ready_low", bad, 0);
        chk("hold_no_writes", wa.size(), 0);
        chk("hold_cs", int'(bus.cs_display), 1);
        release_frame("release0");
        bus.host_valid = 1'b0;

        foreach (tbl[v]) begin
            send_frame(tbl[v].n, tbl[v].last, tbl[v].gaps, tbl[v].base, 1'b0);
            chk("short_on_first_beat", short_first, int'(tbl[v].exp_short_first));
            wait_handoff();
            fc_model++;
            chk("tbl_writes", frame_mismatches(tbl[v].n, tbl[v].base), 0);
            chk("tbl_short", int'(bus.short_frame), int'(tbl[v].exp_short));
            chk("tbl_fc", int'(bus.frame_count), fc_model);
            release_frame("tbl_release");
            chk("tbl_short_kept", int'(bus.short_frame), int'(tbl[v].exp_short));
        end

        // Abort a frame with reset after 57 beats.
        send_frame(57, 1'b0, 1'b0, 90, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (bus.cs_display !== 1'b0) bad++;
        end
        chk("aborted_no_handoff", bad, 0);
        send_frame(100, 1'b0, 1'b0, 11, 1'b0);
        wait_handoff();
        chk("after_reset_writes", frame_mismatches(100, 11), 0);
        chk("after_reset_fc", int'(bus.frame_count), 1);
        release_frame("after_reset_release");

        // 256 frames from reset with spurious frame-done pulses during LOAD.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        fc_model = 0;
        for (int f = 0; f < 256; f++) begin
            send_frame(100, 1'b0, 1'b0, f, 1'b1);
            wait_handoff();
            fc_model = (fc_model + 1) & 255;
            chk("wrap_writes", frame_mismatches(100, f), 0);
            chk("wrap_fc", int'(bus.frame_count), fc_model);
            release_frame("wrap_release");
        end
        chk("fc_wrapped", int'(bus.frame_count), 0);
        chk("we_while_cs", we_cs_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysmem_frame_loader.md
Name: sysmem_frame_loader

Overview:
- Host-side writer for the system-memory frame store. The display controller reads this store.
- Accepts pixel-component bytes from the host over a valid/ready handshake and writes them sequentially into system memory.
- Pads short frames and raises CSDisplay to hand the full frame to the display controller.
- Blocks host writes until the display controller pulses frame-done, then reopens the store for the next frame.

Parameters:
- DEPTH, 100, number of system-memory entries per frame (R,G,B components in order).
- AW, 7, address width; must satisfy 2^AW >= DEPTH.
- DW, 8, data width of one component.
- PAD, 0, value written to unfilled entries after an early HostLast.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- ResetN  in  1  synchronous active-low reset, sampled on the rising edge of Clock.
- HostData  in  DW  component byte from host.
- HostValid  in  1  HostData valid.
- HostLast  in  1  qualifies the final beat of a frame; valid only with HostValid.
- HostReady  out  1  loader accepts a beat this cycle.
- SMAddr  out  AW  system-memory write address.
- SMData  out  DW  system-memory write data.
- SMWE  out  1  system-memory write enable (one write per cycle).
- CSDisplay  out  1  0 = loader owns the store; 1 = frame handed to the display controller.
- DispFrameDone  in  1  single-cycle pulse: display controller has finished reading the frame.
- ShortFrame  out  1  sticky flag: last frame ended early and was padded; cleared on the next accepted first beat.
- FrameCount  out  8  number of completed hand-offs, wraps at 255 -> 0.

Behaviour:
- Reset (ResetN=0 at an edge):
  - state=LOAD, address counter=0.
  - HostReady=0, SMWE=0, SMAddr=0, SMData=0, CSDisplay=0, ShortFrame=0, FrameCount=0.
  - Reset mid-frame discards partial data; no hand-off is issued.
- Outputs are registered. HostReady is 1 in LOAD from the first cycle after reset is released.
- States:
  - LOAD: HostReady=1. A beat is accepted when HostValid&HostReady at an edge.
    - On acceptance: next cycle SMWE=1, SMAddr=counter, SMData=HostData; counter increments. Write latency is 1 cycle from acceptance.
    - If the accepted beat has counter==DEPTH-1: go to HANDOFF. HostLast on that beat is ignored; it is the expected end of frame.
    - If HostLast is accepted with counter<DEPTH-1: set ShortFrame and go to PAD.
    - With no beat accepted, SMWE=0.
  - PAD: HostReady=0. Write PAD at each remaining address, one per cycle, SMWE=1, through DEPTH-1, then go to HANDOFF.
  - HANDOFF: one cycle. SMWE=0, HostReady=0. CSDisplay goes to 1 and counter resets to 0. FrameCount increments on entering WAIT_DONE.
  - WAIT_DONE: CSDisplay=1, HostReady=0, SMWE=0. On DispFrameDone: CSDisplay=0 and go to LOAD.
    - HostReady rises in the same cycle CSDisplay falls, one cycle after the DispFrameDone edge.
- Address arithmetic:
  - The counter never exceeds DEPTH-1. It wraps to 0 only via HANDOFF.
  - Unused address codes (DEPTH..2^AW-1) are never driven.
- DispFrameDone outside WAIT_DONE is ignored.
- HostValid while HostReady=0 is not accepted. The host must hold data, and no beat is lost or duplicated.
- HostLast on the first beat (counter==0) is a short frame: write 1 beat, pad DEPTH-1 entries.
- ShortFrame clears on the first accepted beat of the next frame. It does not clear on DispFrameDone.
- SMWE is never 1 while CSDisplay=1.

Test Plan:
- Reset then stream 100 beats (data = index) with HostValid held high:
  - 100 consecutive SMWE cycles, SMAddr 0..99, SMData 0..99.
  - CSDisplay=1 two cycles after the 100th acceptance; FrameCount=1; HostReady=0.
- In WAIT_DONE, hold HostValid=1 for 20 cycles, then pulse DispFrameDone:
  - No SMWE and no acceptance during the hold.
  - CSDisplay=0 and HostReady=1 on the next cycle; next write lands at SMAddr=0.
- Stream 40 beats with HostLast on beat 40:
  - Addresses 0..39 get data; 40..99 get PAD, one per cycle.
  - ShortFrame=1, then hand-off.
- Random HostValid gaps (about 50%) over a full frame: written sequence is exactly the accepted data in order, with no address skipped or repeated.
- ResetN=0 after 57 beats, then a full frame:
  - All outputs return to their reset values; CSDisplay is never raised for the aborted frame.
  - The new frame starts at SMAddr=0; FrameCount=1 after its hand-off.
- 256 back-to-back frames with immediate DispFrameDone: FrameCount wraps to 0; spurious DispFrameDone pulses during LOAD have no effect.
